rfsh_fetch_arb: RTL and testbench
=================================

# rfsh_fetch_arb

Multi-channel background memory fetch engine that steals SDRAM read cycles during Z80 refresh (nRFSH low), when the CPU never uses the bus. It generalises the single-client tape fetch path to CHANNELS clients (tape, future snapshot/DMA readers) with round-robin arbitration, a one-byte cache per channel, a configurable access delay and abort-on-window-close. It sits between the CPU/sram mux (refresh leg) and the background readers.

## Interface
- CHANNELS, 2: number of client channels, 1..8.
- AW, 25: memory address width.
- ACK_DELAY, 7: counter load value; read data is captured ACK_DELAY-1 cycles after start. Minimum 2.
- clk_sys  in  1  system clock.
- cold_reset  in  1  reset, asynchronous, active-high.
- nRFSH  in  1  CPU refresh strobe, synchronous to clk_sys.
- ch_req  in  CHANNELS  per-channel "want byte at ch_addr".
- ch_addr  in  CHANNELS*AW  packed addresses; channel i at [i*AW +: AW].
- ch_flush  in  CHANNELS  invalidate channel i cache (one-cycle pulse).
- ch_data  out  CHANNELS*8  cached byte per channel.
- ch_valid  out  CHANNELS  ch_data holds the byte at the current ch_addr.
- mem_rd  out  1  read strobe to the sram mux refresh leg.
- mem_addr  out  AW  read address, held stable while mem_rd=1.
- mem_din  in  8  sram read data.
- busy  out  1  fetch in progress (state FETCH).

## Operation
- Per channel: cache_addr[AW], cache_data[8], cache_vld. ch_valid[i] = cache_vld[i] && cache_addr[i]==ch_addr[i] (combinational). ch_data[i] = cache_data[i].
- Channel i is eligible when ch_req[i] && !ch_valid[i] && !ch_flush[i].
- nrfsh_q registers nRFSH; window start = !nRFSH && nrfsh_q.
- FSM states: IDLE, FETCH, WAIT_HI.
- IDLE: on window start with ≥1 eligible channel: grant the first eligible channel at or after rr_ptr (wrapping), latch its address into mem_addr and its index into sel, mem_rd<=1, cnt<=ACK_DELAY, go to FETCH. No eligible channel: stay in IDLE.
- FETCH: cnt decrements each cycle. When cnt==1: cache_data[sel]<=mem_din, cache_addr[sel]<=mem_addr, cache_vld[sel]<=1, mem_rd<=0, rr_ptr<=sel+1 (mod CHANNELS), go to WAIT_HI.
- Abort: nRFSH sampled high while in FETCH (takes priority over cnt==1): mem_rd<=0, cnt<=0, cache and rr_ptr unchanged, go to IDLE. The channel retries at the next window.
- WAIT_HI: go to IDLE when nRFSH is high. At most one fetch per refresh window.
- ch_flush[i]: cache_vld[i]<=0. If it coincides with, or arrives during, a FETCH for i, the capture is discarded (cache_vld[i] stays 0).
- A ch_addr change mid-fetch does not affect the fetch: the byte is cached under the latched address, so ch_valid stays 0 if the addresses differ. Dropping ch_req mid-fetch does not cancel the fetch.

## Timing
- Reset: state IDLE, mem_rd=0, mem_addr=0, busy=0, all cache_vld=0, cache_data=0, cache_addr=0, rr_ptr=0, cnt=0, nrfsh_q=1, ch_valid=0, ch_data=0.
- Edge E0 (window start detected): mem_rd=1 from E0.
- mem_din is sampled at edge E0+ACK_DELAY-1. mem_rd is high for ACK_DELAY-1 cycles.
- ch_valid rises the cycle after capture.
- Refresh low must last ≥ACK_DELAY clk_sys cycles for completion; a shorter window always aborts.
- With all channels continuously eligible, service order is 0,1,…,CHANNELS-1,0.

## Structure
- Package rfsh_fetch_pkg: state enum fsm_t {IDLE, FETCH, WAIT_HI}; localparam CW = $clog2(CHANNELS) (minimum 1).
- Sub-module rr_pick: combinational round-robin first-eligible finder. Inputs are the eligible vector and rr_ptr; outputs are grant index and any.
- Top module holds the FSM, counter, per-channel caches and output regs. Estimated size is about 200 lines.

## Test plan
- Reset, CHANNELS=2, ACK_DELAY=7. Ch0 req addr 0x000100, memory byte 0xA5, refresh low 8 cycles -> mem_rd high 6 cycles with mem_addr=0x000100; ch_data[0]=0xA5; ch_valid[0]=1 next cycle.
- Both channels requesting, four windows -> grants in order 0,1,0,1. After ch0 is satisfied and its addr unchanged, grants are 1 only.
- Refresh low 4 cycles -> mem_rd drops on the cycle after nRFSH rises, no cache update. Next 8-cycle window -> completes.
- Ch0 addr changes 0x100→0x101 mid-fetch -> cache_addr=0x100, ch_valid[0]=0. Next window fetches 0x101.
- ch_flush[0] during FETCH of ch0 -> ch_valid[0]=0 after completion; refetch next window.
- cold_reset asserted mid-FETCH -> mem_rd=0, busy=0, all ch_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/rfsh_fetch_pkg.sv
// Shared types and helpers for the refresh-cycle background fetch engine.
package rfsh_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    WAIT_HI = 2'd2
  } fsm_t;

  // Width of a channel index; a single channel still gets a one-bit index.
  function automatic int cw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rfsh_fetch_arb_rr_pick.sv
// Combinational round-robin finder: first eligible channel at or after rr_ptr, wrapping.
module rr_pick
  import rfsh_fetch_pkg::*;
#(
  parameter int N  = 2,
  parameter int CW = 1
) (
  input  logic [N-1:0]  eligible,
  input  logic [CW-1:0] rr_ptr,
  output logic [CW-1:0] grant,
  output logic          any
);

  logic [CW-1:0] idx;

  // Scan from farthest to nearest offset so the nearest eligible channel wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = |eligible;
    for (int k = N - 1; k >= 0; k--) begin
      idx = CW'((int'(rr_ptr) + k) % N);
      if (eligible[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/rfsh_fetch_arb.sv
// Steals SDRAM read cycles during Z80 refresh windows and serves several
// background readers, each through a one-byte cache, with round-robin arbitration.
module rfsh_fetch_arb
  import rfsh_fetch_pkg::*;
#(
  parameter int CHANNELS  = 2,
  parameter int AW        = 25,
  parameter int ACK_DELAY = 7
) (
  input  logic                   clk_sys,
  input  logic                   cold_reset,
  input  logic                   nRFSH,
  input  logic [CHANNELS-1:0]    ch_req,
  input  logic [CHANNELS*AW-1:0] ch_addr,
  input  logic [CHANNELS-1:0]    ch_flush,
  output logic [CHANNELS*8-1:0]  ch_data,
  output logic [CHANNELS-1:0]    ch_valid,
  output logic                   mem_rd,
  output logic [AW-1:0]          mem_addr,
  input  logic [7:0]             mem_din,
  output logic                   busy
);

  localparam int CW = cw_of(CHANNELS);
  localparam int DW = $clog2(ACK_DELAY + 1);

  fsm_t              state, state_next;
  logic              nrfsh_q;
  logic              win_start;
  logic [DW-1:0]     cnt, cnt_dec;
  logic [CW-1:0]     sel, rr_ptr, grant, sel_inc;
  logic              any_elig;
  logic              fetch_kill;
  logic              start_fetch, capture, abort;
  logic [CHANNELS-1:0] eligible;
  logic [AW-1:0]     addr_arr   [CHANNELS];
  logic [AW-1:0]     cache_addr [CHANNELS];
  logic [7:0]        cache_data [CHANNELS];
  logic [CHANNELS-1:0] cache_vld;

  assign win_start = !nRFSH && nrfsh_q;
  assign cnt_dec   = cnt - DW'(1);
  assign sel_inc   = (sel == CW'(CHANNELS - 1)) ? '0 : sel + CW'(1);
  assign eligible  = ch_req & ~ch_valid & ~ch_flush;
  assign busy      = (state == FETCH);

  rr_pick #(.N(CHANNELS), .CW(CW)) u_rr_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .any      (any_elig)
  );

  // Unpack the flat address bus and form per-channel hit flags and data.
  always_comb begin
    ch_data  = '0;
    ch_valid = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      addr_arr[i]        = ch_addr[i*AW +: AW];
      ch_data[i*8 +: 8]  = cache_data[i];
      ch_valid[i]        = cache_vld[i] && (cache_addr[i] == addr_arr[i]);
    end
  end

  // State register.
  always_ff @(posedge clk_sys or posedge cold_reset) begin
    if (cold_reset) state <= IDLE;
    else            state <= state_next;
  end

  // Next state and the per-cycle control strobes; a window close during FETCH beats completion.
  always_comb begin
    state_next  = state;
    start_fetch = 1'b0;
    capture     = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (win_start && any_elig) begin
          start_fetch = 1'b1;
          state_next  = FETCH;
        end
      end
      FETCH: begin
        if (nRFSH) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (cnt_dec == DW'(1)) begin
          capture    = 1'b1;
          state_next = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (nRFSH) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Fetch datapath: strobe, latched address/channel, access counter, fairness pointer.
  always_ff @(posedge clk_sys or posedge cold_reset) begin
    if (cold_reset) begin
      nrfsh_q    <= 1'b1;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      cnt        <= '0;
      sel        <= '0;
      rr_ptr     <= '0;
      fetch_kill <= 1'b0;
    end else begin
      nrfsh_q <= nRFSH;
      if (start_fetch) begin
        mem_addr   <= addr_arr[grant];
        sel        <= grant;
        mem_rd     <= 1'b1;
        cnt        <= DW'(ACK_DELAY);
        fetch_kill <= 1'b0;
      end else if (abort) begin
        mem_rd <= 1'b0;
        cnt    <= '0;
      end else if (capture) begin
        mem_rd <= 1'b0;
        cnt    <= '0;
        rr_ptr <= sel_inc;
      end else if (state == FETCH) begin
        cnt <= cnt_dec;
        if (ch_flush[sel]) fetch_kill <= 1'b1;
      end
    end
  end

  // Per-channel caches: flush always clears, and a flushed fetch never marks its channel valid.
  always_ff @(posedge clk_sys or posedge cold_reset) begin
    if (cold_reset) begin
      cache_vld <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cache_addr[i] <= '0;
        cache_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (ch_flush[i]) cache_vld[i] <= 1'b0;
      end
      if (capture && !fetch_kill && !ch_flush[sel]) begin
        cache_data[sel] <= mem_din;
        cache_addr[sel] <= mem_addr;
        cache_vld[sel]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rfsh_fetch_arb.sv
// Directed bench for rfsh_fetch_arb: two channels, seven-cycle access delay.
module tb_rfsh_fetch_arb;

  localparam int CHANNELS  = 2;
  localparam int AW        = 25;
  localparam int ACK_DELAY = 7;

  logic                   clk_sys;
  logic                   cold_reset;
  logic                   nRFSH;
  logic [CHANNELS-1:0]    ch_req;
  logic [CHANNELS*AW-1:0] ch_addr;
  logic [CHANNELS-1:0]    ch_flush;
  logic [CHANNELS*8-1:0]  ch_data;
  logic [CHANNELS-1:0]    ch_valid;
  logic                   mem_rd;
  logic [AW-1:0]          mem_addr;
  logic [7:0]             mem_din;
  logic                   busy;

  int checks = 0;
  int errors = 0;

  int          rd_cyc;
  logic [AW-1:0] rd_addr;
  logic        addr_stable;
  logic        rd_after_rise;
  int          vchg_iter;
  logic [7:0]  rd_cnt;

  rfsh_fetch_arb #(.CHANNELS(CHANNELS), .AW(AW), .ACK_DELAY(ACK_DELAY)) dut (
    .clk_sys    (clk_sys),
    .cold_reset (cold_reset),
    .nRFSH      (nRFSH),
    .ch_req     (ch_req),
    .ch_addr    (ch_addr),
    .ch_flush   (ch_flush),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .busy       (busy)
  );

  // 100 MHz system clock.
  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Memory model: the byte (low address byte + 0xA5) is only present on the exact capture edge.
  always_ff @(posedge clk_sys or posedge cold_reset) begin
    if (cold_reset) rd_cnt <= '0;
    else            rd_cnt <= mem_rd ? rd_cnt + 8'd1 : 8'd0;
  end
  assign mem_din = (mem_rd && rd_cnt == 8'd5) ? (mem_addr[7:0] + 8'hA5) : 8'hEE;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic nrfsh_v);
    nRFSH = nrfsh_v;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic applyReset();
    cold_reset = 1'b1;
    nRFSH      = 1'b1;
    ch_req     = '0;
    ch_flush   = '0;
    ch_addr    = '0;
    repeat (2) @(posedge clk_sys);
    #1;
    cold_reset = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
  endtask

  // One refresh window: `low` cycles of nRFSH low, then three high cycles.
  task automatic runWindow(input int low, input int chg_iter, input logic [AW-1:0] chg_addr,
                           input int flush_iter);
    logic [CHANNELS-1:0] v0;
    v0            = ch_valid;
    rd_cyc        = 0;
    rd_addr       = '0;
    addr_stable   = 1'b1;
    rd_after_rise = 1'b0;
    vchg_iter     = -1;
    for (int i = 0; i < low + 3; i++) begin
      if (i == chg_iter) ch_addr[0 +: AW] = chg_addr;
      ch_flush = (i == flush_iter) ? 2'b01 : 2'b00;
      applyStimulus((i < low) ? 1'b0 : 1'b1);
      if (mem_rd) begin
        if (rd_cyc > 0 && mem_addr !== rd_addr) addr_stable = 1'b0;
        rd_addr = mem_addr;
        rd_cyc++;
      end
      if (i == low) rd_after_rise = mem_rd;
      if (vchg_iter < 0 && ch_valid !== v0) vchg_iter = i;
    end
    ch_flush = '0;
  endtask

  // Directed sequence of scenarios.
  initial begin
    cold_reset = 1'b1;
    nRFSH      = 1'b1;
    ch_req     = '0;
    ch_flush   = '0;
    ch_addr    = '0;
    #3;
    checkOutput("reset_mem_rd", mem_rd, 0);
    checkOutput("reset_mem_addr", mem_addr, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_valid", ch_valid, 0);
    checkOutput("reset_data", ch_data, 0);

    // Single fetch for channel 0.
    applyReset();
    ch_req = 2'b01;
    ch_addr[0 +: AW] = 25'h100;
    runWindow(8, -1, '0, -1);
    checkOutput("t1_rd_cycles", rd_cyc, 6);
    checkOutput("t1_rd_addr", rd_addr, 32'h100);
    checkOutput("t1_addr_stable", addr_stable, 1);
    checkOutput("t1_valid_iter", vchg_iter, 6);
    checkOutput("t1_data0", ch_data[7:0], 8'hA5);
    checkOutput("t1_valid", ch_valid, 2'b01);
    checkOutput("t1_busy", busy, 0);

    // Round-robin with both channels eligible every window.
    applyReset();
    ch_req = 2'b11;
    ch_addr[0 +: AW] = 25'h100; ch_addr[AW +: AW] = 25'h2C0;
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w0", rd_addr, 32'h100);
    ch_addr[0 +: AW] = 25'h101; ch_addr[AW +: AW] = 25'h2C1;
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w1", rd_addr, 32'h2C1);
    ch_addr[0 +: AW] = 25'h102; ch_addr[AW +: AW] = 25'h2C2;
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w2", rd_addr, 32'h102);
    ch_addr[0 +: AW] = 25'h103; ch_addr[AW +: AW] = 25'h2C3;
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w3", rd_addr, 32'h2C3);
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w4", rd_addr, 32'h103);
    checkOutput("rr_w4_data0", ch_data[7:0], 8'hA8);
    ch_addr[AW +: AW] = 25'h2C5;
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w5", rd_addr, 32'h2C5);
    ch_addr[AW +: AW] = 25'h2C6;
    runWindow(8, -1, '0, -1);
    checkOutput("rr_w6", rd_addr, 32'h2C6);
    checkOutput("rr_w6_data1", ch_data[15:8], 8'h6B);
    checkOutput("rr_w6_valid", ch_valid, 2'b11);
    runWindow(8, -1, '0, -1);
    checkOutput("rr_idle_window", rd_cyc, 0);

    // Short window aborts, next full window completes.
    ch_req = 2'b01;
    ch_addr[0 +: AW] = 25'h110;
    runWindow(4, -1, '0, -1);
    checkOutput("abort_rd_cycles", rd_cyc, 4);
    checkOutput("abort_rd_after_rise", rd_after_rise, 0);
    checkOutput("abort_valid", ch_valid, 2'b10);
    checkOutput("abort_data0", ch_data[7:0], 8'hA8);
    runWindow(8, -1, '0, -1);
    checkOutput("retry_rd_addr", rd_addr, 32'h110);
    checkOutput("retry_data0", ch_data[7:0], 8'hB5);
    checkOutput("retry_valid", ch_valid, 2'b11);

    // Address change mid-fetch: byte cached under the latched address.
    ch_addr[0 +: AW] = 25'h100;
    runWindow(8, 3, 25'h101, -1);
    checkOutput("addrchg_rd_addr", rd_addr, 32'h100);
    checkOutput("addrchg_stable", addr_stable, 1);
    checkOutput("addrchg_data0", ch_data[7:0], 8'hA5);
    checkOutput("addrchg_valid", ch_valid, 2'b10);
    runWindow(8, -1, '0, -1);
    checkOutput("addrchg_refetch_addr", rd_addr, 32'h101);
    checkOutput("addrchg_refetch_data0", ch_data[7:0], 8'hA6);
    checkOutput("addrchg_refetch_valid", ch_valid, 2'b11);

    // Flush during FETCH, then flush on the capture edge itself.
    ch_addr[0 +: AW] = 25'h120;
    runWindow(8, -1, '0, 3);
    checkOutput("flush_mid_rd_cycles", rd_cyc, 6);
    checkOutput("flush_mid_valid", ch_valid, 2'b10);
    runWindow(8, -1, '0, -1);
    checkOutput("flush_mid_refetch_data0", ch_data[7:0], 8'hC5);
    checkOutput("flush_mid_refetch_valid", ch_valid, 2'b11);
    ch_addr[0 +: AW] = 25'h121;
    runWindow(8, -1, '0, 6);
    checkOutput("flush_cap_rd_cycles", rd_cyc, 6);
    checkOutput("flush_cap_valid", ch_valid, 2'b10);
    runWindow(8, -1, '0, -1);
    checkOutput("flush_cap_refetch_data0", ch_data[7:0], 8'hC6);
    checkOutput("flush_cap_refetch_valid", ch_valid, 2'b11);

    // Asynchronous reset in the middle of a fetch.
    ch_addr[0 +: AW] = 25'h130;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("prerst_busy", busy, 1);
    checkOutput("prerst_mem_rd", mem_rd, 1);
    checkOutput("prerst_valid", ch_valid, 2'b10);
    #2;
    cold_reset = 1'b1;
    #1;
    checkOutput("rst_mem_rd", mem_rd, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_valid", ch_valid, 0);
    checkOutput("rst_data", ch_data, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    cold_reset = 1'b0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    runWindow(8, -1, '0, -1);
    checkOutput("post_rst_rd_addr", rd_addr, 32'h130);
    checkOutput("post_rst_data0", ch_data[7:0], 8'hD5);
    checkOutput("post_rst_valid", ch_valid, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
